// File: rtl/jk_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and op classification for the JK bank sequencer.
// Pure declarations; no logic, no latency, no flow control.
package jk_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_CLEAR  = 3'd2,
        OP_SET    = 3'd3,
        OP_TOGGLE = 3'd4,
        OP_CNT_UP = 3'd5,
        OP_CNT_DN = 3'd6,
        OP_SHL    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Counting and shifting repeat for cmd_steps cycles; everything else is one step.
    function automatic logic is_multi_step(input logic [2:0] op);
        return (op == OP_CNT_UP) || (op == OP_CNT_DN) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command/status bundle between a host and jk_bank_ctrl: valid/ready command, abort, status.
// No latency of its own; cmd_valid must be held by the host until cmd_ready is seen.
interface jk_bank_ctrl_if #(
    parameter int N      = 4,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [N-1:0]      cmd_data;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps, abort,
        input  cmd_ready, busy, done, aborted
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps, abort,
        output cmd_ready, busy, done, aborted
    );
endinterface

// File: rtl/jk_drive_gen.sv
// Combinational J/K drive for the bank from the captured op/data and bank feedback.
// Zero latency; forces J=K=0 whenever en is low so the bank holds.
module jk_drive_gen
    import jk_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] data,
    input  logic [N-1:0] q_fb,
    input  logic         en,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);
    logic [N-1:0] up_t;
    logic [N-1:0] dn_t;
    logic [N-1:0] shl_v;

    // Ripple prefix ANDs: a bit toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_t     = '0;
        dn_t     = '0;
        shl_v    = '0;
        up_t[0]  = 1'b1;
        dn_t[0]  = 1'b1;
        shl_v[0] = data[0];
        for (int i = 1; i < N; i++) begin
            up_t[i]  = up_t[i-1] & q_fb[i-1];
            dn_t[i]  = dn_t[i-1] & ~q_fb[i-1];
            shl_v[i] = q_fb[i-1];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (en) begin
            case (op)
                OP_LOAD:   begin j = data;  k = ~data;  end
                OP_CLEAR:  begin j = '0;    k = '1;     end
                OP_SET:    begin j = '1;    k = '0;     end
                OP_TOGGLE: begin j = data;  k = data;   end
                OP_CNT_UP: begin j = up_t;  k = up_t;   end
                OP_CNT_DN: begin j = dn_t;  k = dn_t;   end
                OP_SHL:    begin j = shl_v; k = ~shl_v; end
                default:   begin j = '0;    k = '0;     end
            endcase
        end
    end
endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequences load/set/clear/toggle/count/shift on a JK bank; single-step ops enable one edge, done follows.
// Commands are accepted only in IDLE (cmd_ready); a held cmd_valid waits until the current op retires.
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int STEP_W = 8
) (
    input  logic          clk,
    input  logic          preset,
    jk_bank_ctrl_if.slave cmd,
    input  logic [N-1:0]  q_fb,
    output logic          jk_en,
    output logic [N-1:0]  j,
    output logic [N-1:0]  k
);
    state_e            state, state_nxt;
    logic [2:0]        op_q, op_nxt;
    logic [N-1:0]      data_q, data_nxt;
    logic [STEP_W-1:0] rem_q, rem_nxt;
    logic              abt_q, abt_nxt;

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state  <= S_IDLE;
            op_q   <= '0;
            data_q <= '0;
            rem_q  <= '0;
            abt_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            data_q <= data_nxt;
            rem_q  <= rem_nxt;
            abt_q  <= abt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        data_nxt  = data_q;
        rem_nxt   = rem_q;
        abt_nxt   = abt_q;
        jk_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_nxt   = cmd.cmd_op;
                    data_nxt = cmd.cmd_data;
                    rem_nxt  = cmd.cmd_steps;
                    abt_nxt  = 1'b0;
                    if (!is_multi_step(cmd.cmd_op))
                        state_nxt = S_EXEC;
                    else if (cmd.cmd_steps == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_RUN;
                end
            end
            S_EXEC: begin
                jk_en     = 1'b1;
                state_nxt = S_DONE;
            end
            S_RUN: begin
                // The step in an abort cycle still executes; we stop after it.
                jk_en   = 1'b1;
                rem_nxt = rem_q - STEP_W'(1);
                if (cmd.abort || rem_q == STEP_W'(1)) begin
                    state_nxt = S_DONE;
                    abt_nxt   = cmd.abort;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cmd.cmd_ready = (state == S_IDLE) & ~preset;
    assign cmd.busy      = (state != S_IDLE);
    assign cmd.done      = (state == S_DONE);
    assign cmd.aborted   = (state == S_DONE) & abt_q;

    jk_drive_gen #(.N(N)) u_drive (
        .op   (op_q),
        .data (data_q),
        .q_fb (q_fb),
        .en   (jk_en),
        .j    (j),
        .k    (k)
    );
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl driving a 4-bit behavioural JK bank.
// Expected values are hand-computed from the command semantics.
module tb_jk_bank_ctrl;
    import jk_ctrl_pkg::*;

    localparam int N      = 4;
    localparam int STEP_W = 8;

    logic         clk = 1'b0;
    logic         preset;
    logic         jk_en;
    logic [N-1:0] j, k, q;
    int           tests = 0;
    int           fails = 0;

    jk_bank_ctrl_if #(.N(N), .STEP_W(STEP_W)) cif ();

    jk_bank_ctrl #(.N(N), .STEP_W(STEP_W)) dut (
        .clk    (clk),
        .preset (preset),
        .cmd    (cif),
        .q_fb   (q),
        .jk_en  (jk_en),
        .j      (j),
        .k      (k)
    );

    always #5 clk = ~clk;

    // Bank of enable-gated JK cells; not reset by the controller.
    always @(posedge clk) begin
        for (int b = 0; b < N; b++) begin
            if (jk_en) begin
                case ({j[b], k[b]})
                    2'b01:   q[b] <= 1'b0;
                    2'b10:   q[b] <= 1'b1;
                    2'b11:   q[b] <= ~q[b];
                    default: q[b] <= q[b];
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [N-1:0] d, input logic [STEP_W-1:0] s);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        cif.cmd_steps = s;
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic [N-1:0] d,
                          input logic [N-1:0] ej, input logic [N-1:0] ek, input logic [N-1:0] eq);
        send(op, d, '0);
        chk({tag, "_en"}, jk_en, 1);
        chk({tag, "_j"}, j, ej);
        chk({tag, "_k"}, k, ek);
        chk({tag, "_rdy0"}, cif.cmd_ready, 0);
        tick();
        chk({tag, "_q"}, q, eq);
        chk({tag, "_done"}, cif.done, 1);
        chk({tag, "_en0"}, jk_en, 0);
        chk({tag, "_abt"}, cif.aborted, 0);
        tick();
        chk({tag, "_rdy1"}, cif.cmd_ready, 1);
        chk({tag, "_done0"}, cif.done, 0);
    endtask

    initial begin
        preset        = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;
        cif.cmd_data  = '0;
        cif.cmd_steps = '0;
        cif.abort     = 1'b0;
        tick();
        tick();
        chk("rst_rdy", cif.cmd_ready, 0);
        chk("rst_busy", cif.busy, 0);
        chk("rst_done", cif.done, 0);
        chk("rst_abt", cif.aborted, 0);
        chk("rst_en", jk_en, 0);
        chk("rst_jk", {j, k}, 0);
        preset = 1'b0;
        tick();
        chk("rel_rdy", cif.cmd_ready, 1);

        // Single-step ops
        single("load", OP_LOAD,   4'b1010, 4'b1010, 4'b0101, 4'b1010);
        single("nop",  OP_NOP,    4'b1111, 4'b0000, 4'b0000, 4'b1010);
        single("tgl",  OP_TOGGLE, 4'b0110, 4'b0110, 4'b0110, 4'b1100);
        single("set",  OP_SET,    4'b0000, 4'b1111, 4'b0000, 4'b1111);
        single("clr",  OP_CLEAR,  4'b0000, 4'b0000, 4'b1111, 4'b0000);

        // Count up across wrap: 1110 -> 1111 -> 0000 -> 0001
        single("ld_e", OP_LOAD, 4'b1110, 4'b1110, 4'b0001, 4'b1110);
        send(OP_CNT_UP, '0, 8'd3);
        chk("up1_en", jk_en, 1);
        chk("up1_j", j, 4'b0001);
        tick();
        chk("up2_q", q, 4'b1111);
        chk("up2_en", jk_en, 1);
        chk("up2_j", j, 4'b1111);
        tick();
        chk("up3_q", q, 4'b0000);
        chk("up3_en", jk_en, 1);
        chk("up3_done", cif.done, 0);
        tick();
        chk("up_q", q, 4'b0001);
        chk("up_done", cif.done, 1);
        chk("up_en0", jk_en, 0);
        tick();
        chk("up_rdy", cif.cmd_ready, 1);

        // Count down across wrap: 0000 -> 1111 -> 1110
        single("ld_0", OP_LOAD, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        send(OP_CNT_DN, '0, 8'd2);
        chk("dn1_j", j, 4'b1111);
        chk("dn1_k", k, 4'b1111);
        tick();
        chk("dn2_q", q, 4'b1111);
        chk("dn2_j", j, 4'b0001);
        tick();
        chk("dn_q", q, 4'b1110);
        chk("dn_done", cif.done, 1);
        tick();

        // Shift left with abort during second RUN cycle
        single("ld_0b", OP_LOAD, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        send(OP_SHL, 4'b0001, 8'd5);
        chk("shl1_j", j, 4'b0001);
        chk("shl1_k", k, 4'b1110);
        tick();
        chk("shl2_q", q, 4'b0001);
        chk("shl2_en", jk_en, 1);
        cif.abort = 1'b1;
        tick();
        cif.abort = 1'b0;
        chk("shl_q", q, 4'b0011);
        chk("shl_done", cif.done, 1);
        chk("shl_abt", cif.aborted, 1);
        chk("shl_en0", jk_en, 0);
        tick();
        chk("shl_rdy", cif.cmd_ready, 1);
        chk("shl_hold", q, 4'b0011);

        // Zero-step count, with a second command held valid while busy
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_CNT_UP;
        cif.cmd_steps = 8'd0;
        cif.cmd_data  = '0;
        tick();
        cif.cmd_op    = OP_LOAD;
        cif.cmd_data  = 4'b0101;
        chk("z_done", cif.done, 1);
        chk("z_en", jk_en, 0);
        chk("z_rdy", cif.cmd_ready, 0);
        chk("z_abt", cif.aborted, 0);
        tick();
        chk("z_q", q, 4'b0011);
        chk("z_rdy1", cif.cmd_ready, 1);
        chk("z_en1", jk_en, 0);
        tick();
        cif.cmd_valid = 1'b0;
        chk("held_en", jk_en, 1);
        chk("held_j", j, 4'b0101);
        tick();
        chk("held_q", q, 4'b0101);
        chk("held_done", cif.done, 1);
        tick();

        // Preset in the middle of a long count
        send(OP_CNT_UP, '0, 8'd10);
        chk("pr_run", cif.busy, 1);
        tick();
        chk("pr_q1", q, 4'b0110);
        tick();
        chk("pr_q2", q, 4'b0111);
        preset = 1'b1;
        #1;
        chk("pr_en", jk_en, 0);
        chk("pr_busy", cif.busy, 0);
        chk("pr_done", cif.done, 0);
        chk("pr_rdy", cif.cmd_ready, 0);
        chk("pr_jk", {j, k}, 0);
        #2;
        preset = 1'b0;
        tick();
        chk("pr_rel_rdy", cif.cmd_ready, 1);
        chk("pr_rel_q", q, 4'b0111);
        tick();
        chk("pr_stop_q", q, 4'b0111);
        chk("pr_stop_en", jk_en, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for a bank of N enable-gated JK flip-flop cells.
- Generates the per-bit J/K drive and the shared enable for the bank, using the bank's Q outputs as feedback.
- Implements load, set, clear, toggle, up/down counting and left shift as single-step or multi-step operations behind a valid/ready command port.
- Sits between a host FSM or testbench and the JK cell bank, which shares clk with this block.

Parameters:
- N, 4, bank width in bits (1..16).
- STEP_W, 8, width of the step-count field.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- preset  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  operation code, see Behaviour.
- cmd_data  input  N  operand: load value, toggle mask, or shift-in bit (bit 0).
- cmd_steps  input  STEP_W  number of enabled clock steps for COUNT and SHIFT ops.
- abort  input  1  synchronous request to stop a running multi-step op.
- q_fb  input  N  current Q of the bank.
- jk_en  output  1  enable to every bank cell.
- j  output  N  J drive per cell.
- k  output  N  K drive per cell.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  valid with done; 1 if the op ended by abort.

Behaviour:
- Opcodes:
  - 0 NOP: J=K=0.
  - 1 LOAD: J=data, K=~data.
  - 2 CLEAR: J=0, K=all-1.
  - 3 SET: J=all-1, K=0.
  - 4 TOGGLE: J=K=data.
  - 5 CNT_UP: J[i]=K[i]=AND of q_fb[i-1:0]; bit 0 is always 1.
  - 6 CNT_DN: J[i]=K[i]=AND of ~q_fb[i-1:0]; bit 0 is always 1.
  - 7 SHL: J[0]=data[0], K[0]=~data[0]; J[i]=q_fb[i-1], K[i]=~q_fb[i-1].
- Ops 0–4 are single-step. Ops 5–7 run for cmd_steps enabled cycles.
- Op, data and steps are captured into registers on accept. j/k are combinational from the captured op/data and q_fb. j=k=0 whenever jk_en=0.
- States:
  - IDLE: cmd_ready=1. Accept when cmd_valid and cmd_ready. Single-step op goes to EXEC. Multi-step op with steps>0 goes to RUN. Multi-step op with steps=0 goes directly to DONE, with no jk_en pulse.
  - EXEC: jk_en=1 for exactly one cycle, then DONE.
  - RUN: jk_en=1 every cycle; remaining count decrements each cycle. Leave RUN for DONE after the cycle in which remaining=1. If abort=1 in a RUN cycle, that cycle's step still executes (jk_en=1), then go to DONE with aborted=1.
  - DONE: done=1 for one cycle, jk_en=0, then IDLE.
- abort is ignored outside RUN. A command presented while busy is not accepted; cmd_valid must be held until accepted.
- busy=1 in EXEC, RUN and DONE. cmd_ready=~busy and ~preset.
- Latency: for a single-step op accepted at edge E0, the bank updates at E1, done is high in cycle E1–E2, and cmd_ready is back in cycle E2. A multi-step op with S steps produces S enabled edges, and done follows the last one.
- Counting wraps naturally: all-1 +1 becomes 0, and 0 −1 becomes all-1. No saturation.
- NOP still takes the EXEC path, asserts jk_en for one cycle with J=K=0 (bank holds), and produces a done pulse.
- preset asserted at any time, including mid-RUN:
  - state goes to IDLE, remaining count to 0, captured op/data to 0;
  - jk_en=0, j=k=0, done=0, aborted=0, busy=0, cmd_ready=0 while asserted;
  - cmd_ready=1 from the first clk edge after deassertion.
- Bank state is not reset by this block.

Decomposition:
- Shared package jk_ctrl_pkg holds:
  - opcode constants OP_NOP..OP_SHL;
  - state encoding constants S_IDLE, S_EXEC, S_RUN, S_DONE;
  - an is_multi_step(op) function.
- One natural sub-module: jk_drive_gen. It is combinational and maps (op, data, q_fb, en) to (j, k).
- The top level holds the FSM, command capture registers and step counter.
- The bench instantiates N jk-enable cells driven by j/k/jk_en as the DUT load.

Test Plan:
- Reset then LOAD data=4'b1010 -> jk_en high exactly 1 cycle, j=1010/k=0101 in that cycle, bank=1010, done pulse 1 cycle later, aborted=0.
- Bank=1110, CNT_UP steps=3 -> bank sequence 1111, 0000, 0001; exactly 3 jk_en cycles; done after the third step.
- Bank=0000, CNT_DN steps=2 -> bank 1111 then 1110; j=k=1111 on the first step.
- Bank=0000, SHL data[0]=1 steps=5 with abort asserted during the 2nd RUN cycle -> bank 0001, 0011, then stop; done with aborted=1; cmd_ready in the following cycle.
- CNT_UP steps=0 -> no jk_en, done in the cycle after accept, bank unchanged. A second command held valid while busy is accepted only once cmd_ready=1.
- Assert preset mid-RUN of CNT_UP steps=10 -> jk_en, busy and done drop immediately (asynchronously). Count does not resume after release. cmd_ready=1 after the first edge post-release.
